// File: rtl/mysystem_pio_in_irq_if.sv
`default_nettype none
// ============================================================================
// Module      : mysystem_pio_in_irq_if
// Description : Avalon-MM slave bundle for the mysystem input PIO. The fabric
//               side uses the master modport. The PIO uses the slave modport.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface mysystem_pio_in_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface
`default_nettype wire

// File: rtl/mysystem_pio_in_irq.sv
`default_nettype none
// ============================================================================
// Module      : mysystem_pio_in_irq
// Description : Parametrised Avalon-MM input PIO. It synchronises in_port and
//               captures selected per-bit edges into a sticky write-1-to-clear
//               register. It also drives a maskable registered interrupt.
//               Optional per-bit debounce is enabled by defining
//               MYSYSTEM_PIO_IN_DEBOUNCE_EN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mysystem_pio_in_irq #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,    // 0 rising, 1 falling, 2 any
  parameter int IRQ_TYPE        = 1,    // 0 level, 1 edge
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mysystem_pio_in_irq_if.slave bus,
  input  logic [WIDTH-1:0]     in_port
);

  // Elaboration-time parameter range checks
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mysystem_pio_in_irq: WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("mysystem_pio_in_irq: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("mysystem_pio_in_irq: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_dly_q;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_clr;
  logic [31:0]      readdata_d;
  logic [31:0]      readdata_q;
  logic             irq_d;
  logic             irq_q;
  logic             wr_en;

  // Metastability chain from the asynchronous pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef MYSYSTEM_PIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] db_q;

  for (genvar n = 0; n < WIDTH; n++) begin : g_db_bit
    logic [CW-1:0] cnt_q;

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        db_q[n] <= 1'b0;
      end else if (sync[n] == db_q[n]) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_q[n] <= sync[n];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign data = db_q;
`else
  assign data = sync;
`endif

  assign wr_en       = bus.chipselect && !bus.write_n;
  assign edgecap_clr = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // Per-bit edge selection against the one-cycle-old data
  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      0:       edge_hit = data & ~data_dly_q;
      1:       edge_hit = ~data & data_dly_q;
      default: edge_hit = (data & ~data_dly_q) | (~data & data_dly_q);
    endcase
  end

  // Interrupt source and read mux; the read mux ignores chipselect
  always_comb begin
    irq_d      = (IRQ_TYPE == 0) ? |(data & irqmask_q) : |(edgecap_q & irqmask_q);
    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d[WIDTH-1:0] = data;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  // Register file, edge capture (set beats clear), registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_dly_q <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_dly_q <= data;
      if (wr_en && bus.address == 2'd2) irqmask_q <= bus.writedata[WIDTH-1:0];
      edgecap_q  <= (edgecap_q & ~edgecap_clr) | edge_hit;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_mysystem_pio_in_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mysystem_pio_in_irq
// Description : Self-checking bench for mysystem_pio_in_irq. Three instances
//               cover rising/edge-irq, any-edge/level-irq and a 5-bit
//               falling-edge configuration. They share one bus and have
//               separate chip selects.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mysystem_pio_in_irq;
  localparam int S = 2;
`ifdef MYSYSTEM_PIO_IN_DEBOUNCE_EN
  localparam int DEB = 8;
`else
  localparam int DEB = 0;
`endif
  localparam int LAT = S + DEB;   // pin change to data, in clock edges

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic [2:0]  cs;
  logic        wr_n;
  logic [31:0] wdata;
  logic [31:0] in_p [3];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  mysystem_pio_in_irq_if bus0 ();
  mysystem_pio_in_irq_if bus1 ();
  mysystem_pio_in_irq_if bus2 ();

  assign bus0.address = address; assign bus0.chipselect = cs[0];
  assign bus0.write_n = wr_n;    assign bus0.writedata  = wdata;
  assign bus1.address = address; assign bus1.chipselect = cs[1];
  assign bus1.write_n = wr_n;    assign bus1.writedata  = wdata;
  assign bus2.address = address; assign bus2.chipselect = cs[2];
  assign bus2.write_n = wr_n;    assign bus2.writedata  = wdata;

  wire [31:0] rd_w  [3];
  wire        irq_w [3];
  assign rd_w[0] = bus0.readdata; assign irq_w[0] = bus0.irq;
  assign rd_w[1] = bus1.readdata; assign irq_w[1] = bus1.irq;
  assign rd_w[2] = bus2.readdata; assign irq_w[2] = bus2.irq;

  mysystem_pio_in_irq #(.WIDTH(16), .SYNC_STAGES(S), .EDGE_TYPE(0), .IRQ_TYPE(1),
    .DEBOUNCE_CYCLES(8)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_p[0][15:0]));
  mysystem_pio_in_irq #(.WIDTH(16), .SYNC_STAGES(S), .EDGE_TYPE(2), .IRQ_TYPE(0),
    .DEBOUNCE_CYCLES(8)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_p[1][15:0]));
  mysystem_pio_in_irq #(.WIDTH(5), .SYNC_STAGES(S), .EDGE_TYPE(1), .IRQ_TYPE(1),
    .DEBOUNCE_CYCLES(8)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_p[2][4:0]));

  function automatic int pw(input int d);
    return (d == 2) ? 5 : 16;
  endfunction
  function automatic int pet(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 1;
  endfunction
  function automatic int pit(input int d);
    return (d == 1) ? 0 : 1;
  endfunction
  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // ---------------- behavioural reference model ----------------
  // data is the pin seen S edges later (a delay queue), optionally requiring
  // DEB consecutive differing cycles before a bit is accepted. Registers
  // follow the register-map rules directly.
  logic [31:0] m_q [3][$];
  logic [31:0] m_data [3], m_prev [3], m_cap [3], m_mask [3], m_rd [3];
  logic        m_irq [3];
  int          m_cnt [3][32];

  always @(posedge clk or negedge reset_n) begin
    logic [31:0] wm, od, oc, om, osync, ed, clr;
    logic        wr;
    if (!reset_n) begin
      for (int d = 0; d < 3; d++) begin
        m_q[d].delete();
        for (int k = 0; k < S; k++) m_q[d].push_back(32'd0);
        m_data[d] = 0; m_prev[d] = 0; m_cap[d] = 0; m_mask[d] = 0; m_rd[d] = 0; m_irq[d] = 0;
        for (int b = 0; b < 32; b++) m_cnt[d][b] = 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        wm = wmask(pw(d));
        od = m_data[d]; oc = m_cap[d]; om = m_mask[d];
        osync = m_q[d][0];
        case (pet(d))
          0:       ed = od & ~m_prev[d];
          1:       ed = ~od & m_prev[d];
          default: ed = od ^ m_prev[d];
        endcase
        wr  = cs[d] && !wr_n;
        clr = (wr && address == 2'd3) ? (wdata & wm) : 32'd0;
        m_cap[d] = ((oc & ~clr) | ed) & wm;
        if (wr && address == 2'd2) m_mask[d] = wdata & wm;
        m_irq[d] = (pit(d) == 0) ? |(od & om) : |(oc & om);
        m_rd[d]  = (address == 2'd0) ? od : (address == 2'd2) ? om : (address == 2'd3) ? oc : 32'd0;
        m_prev[d] = od;
        m_q[d].push_back(in_p[d] & wm);
        void'(m_q[d].pop_front());
`ifdef MYSYSTEM_PIO_IN_DEBOUNCE_EN
        for (int b = 0; b < pw(d); b++) begin
          if (osync[b] != od[b]) begin
            m_cnt[d][b]++;
            if (m_cnt[d][b] == DEB) begin
              m_data[d][b] = osync[b];
              m_cnt[d][b]  = 0;
            end
          end else begin
            m_cnt[d][b] = 0;
          end
        end
`else
        m_data[d] = m_q[d][0];
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
    cs[d] = 1'b1; wr_n = 1'b0; address = a; wdata = v;
    tick();
    cs = '0; wr_n = 1'b1;
  endtask

  task automatic rd(input int d, input logic [1:0] a, output logic [31:0] v);
    address = a;
    tick();
    v = rd_w[d];
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b0; cs = '0; wr_n = 1'b1; address = 2'd0; wdata = '0;
    in_p[0] = 32'h0000_A5A5; in_p[1] = '0; in_p[2] = '0;
    repeat (3) tick();
    vectors++; if (rd_w[0] !== 32'd0) begin miscompares++; $display("FAIL reset_readdata got %h want %h", rd_w[0], 32'd0); end
    vectors++; if (irq_w[0] !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq_w[0]); end
    reset_n = 1'b1;
    repeat (LAT + 1) tick();
    vectors++; if (rd_w[0] !== 32'h0000_A5A5) begin miscompares++; $display("FAIL reset_data got %h want %h", rd_w[0], 32'h0000_A5A5); end
    rd(0, 2'd1, v);
    vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL reset_addr1 got %h want 0", v); end
    rd(0, 2'd2, v);
    vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL reset_mask got %h want 0", v); end
    rd(0, 2'd3, v);
    vectors++; if (v !== 32'h0000_A5A5) begin miscompares++; $display("FAIL reset_edgecap got %h want %h", v, 32'h0000_A5A5); end
    vectors++; if (irq_w[0] !== 1'b0) begin miscompares++; $display("FAIL reset_irq_after got %b want 0", irq_w[0]); end
  endtask

  task automatic test_rise_irq();
    logic [31:0] v;
    in_p[0] = '0;
    repeat (LAT + 2) tick();
    wr(0, 2'd3, 32'h0000_FFFF);
    wr(0, 2'd2, 32'h0000_0001);
    in_p[0] = 32'h1;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      if (k == 3 + DEB) in_p[0] = '0;
      if (k == LAT + 1) begin
        vectors++; if (irq_w[0] !== 1'b0) begin miscompares++; $display("FAIL rise_irq_early got %b want 0", irq_w[0]); end
      end
      if (k == LAT + 2) begin
        vectors++; if (irq_w[0] !== 1'b1) begin miscompares++; $display("FAIL rise_irq_set got %b want 1", irq_w[0]); end
      end
    end
    rd(0, 2'd3, v);
    vectors++; if (v !== 32'h1) begin miscompares++; $display("FAIL rise_edgecap got %h want 1", v); end
    wr(0, 2'd3, 32'h1);
    vectors++; if (irq_w[0] !== 1'b1) begin miscompares++; $display("FAIL clear_irq_write_edge got %b want 1", irq_w[0]); end
    tick();
    vectors++; if (irq_w[0] !== 1'b0) begin miscompares++; $display("FAIL clear_irq_drop got %b want 0", irq_w[0]); end
  endtask

  task automatic test_set_wins();
    logic [31:0] v;
    repeat (LAT + 2) tick();
    in_p[0] = 32'h4;
    repeat (LAT) tick();
    wr(0, 2'd3, 32'h4);           // strobe lands on the capture edge
    rd(0, 2'd3, v);
    vectors++; if (v !== 32'h4) begin miscompares++; $display("FAIL set_wins got %h want 4", v); end
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL clear_after got %h want 0", v); end
  endtask

  task automatic test_level();
    logic [31:0] v;
    in_p[1] = 32'h10;
    repeat (LAT + 2) tick();
    vectors++; if (irq_w[1] !== 1'b0) begin miscompares++; $display("FAIL level_masked got %b want 0", irq_w[1]); end
    wr(1, 2'd2, 32'h10);
    vectors++; if (irq_w[1] !== 1'b0) begin miscompares++; $display("FAIL level_write_edge got %b want 0", irq_w[1]); end
    tick();
    vectors++; if (irq_w[1] !== 1'b1) begin miscompares++; $display("FAIL level_irq got %b want 1", irq_w[1]); end
    in_p[1] = '0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      if (k == LAT) begin
        vectors++; if (irq_w[1] !== 1'b1) begin miscompares++; $display("FAIL level_hold got %b want 1", irq_w[1]); end
      end
      if (k == LAT + 1) begin
        vectors++; if (irq_w[1] !== 1'b0) begin miscompares++; $display("FAIL level_drop got %b want 0", irq_w[1]); end
      end
    end
    rd(1, 2'd3, v);
    vectors++; if (v !== 32'h10) begin miscompares++; $display("FAIL anyedge_cap got %h want 10", v); end
  endtask

  task automatic test_width();
    logic [31:0] v;
    in_p[2] = 32'h0A;
    repeat (LAT + 2) tick();
    wr(2, 2'd2, 32'hFFFF_FFFF);
    rd(2, 2'd2, v);
    vectors++; if (v !== 32'h1F) begin miscompares++; $display("FAIL width_mask got %h want 1f", v); end
    wr(2, 2'd0, 32'hFFFF_FFFF);
    rd(2, 2'd0, v);
    vectors++; if (v !== 32'h0A) begin miscompares++; $display("FAIL width_data_ro got %h want 0a", v); end
    rd(2, 2'd3, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL fall_nocap got %h want 0", v); end
    in_p[2] = 32'h02;
    repeat (LAT + 2) tick();
    rd(2, 2'd3, v);
    vectors++; if (v !== 32'h08) begin miscompares++; $display("FAIL fall_cap got %h want 08", v); end
    vectors++; if (irq_w[2] !== 1'b1) begin miscompares++; $display("FAIL fall_irq got %b want 1", irq_w[2]); end
    wr(2, 2'd3, 32'hFFFF_FFFF);
    rd(2, 2'd3, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL width_clear got %h want 0", v); end
  endtask

`ifdef MYSYSTEM_PIO_IN_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] v;
    in_p[0] = '0;
    repeat (LAT + 2) tick();
    wr(0, 2'd3, 32'hFFFF);
    wr(0, 2'd2, 32'h0);
    in_p[0] = 32'h8;
    repeat (5) tick();
    in_p[0] = '0;
    repeat (20) tick();
    rd(0, 2'd0, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL glitch_data got %h want 0", v); end
    rd(0, 2'd3, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL glitch_cap got %h want 0", v); end
    address = 2'd0;
    in_p[0] = 32'h8;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      if (k == LAT) begin
        vectors++; if (rd_w[0] !== 32'h0) begin miscompares++; $display("FAIL db_early got %h want 0", rd_w[0]); end
      end
      if (k == LAT + 1) begin
        vectors++; if (rd_w[0] !== 32'h8) begin miscompares++; $display("FAIL db_level got %h want 8", rd_w[0]); end
      end
    end
    repeat (20 - (LAT + 1)) tick();
    in_p[0] = '0;
    repeat (S + 4) tick();
    reset_n = 1'b0;
    tick();
    vectors++; if (rd_w[0] !== 32'h0) begin miscompares++; $display("FAIL db_reset_rd got %h want 0", rd_w[0]); end
    vectors++; if (irq_w[0] !== 1'b0) begin miscompares++; $display("FAIL db_reset_irq got %b want 0", irq_w[0]); end
    reset_n = 1'b1;
    repeat (LAT + 2) tick();
    vectors++; if (rd_w[0] !== 32'h0) begin miscompares++; $display("FAIL db_after_reset got %h want 0", rd_w[0]); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (rd_w[d] !== m_rd[d]) begin
          miscompares++; $display("FAIL rand_readdata dut%0d cyc%0d got %h want %h", d, i, rd_w[d], m_rd[d]);
        end
        vectors++;
        if (irq_w[d] !== m_irq[d]) begin
          miscompares++; $display("FAIL rand_irq dut%0d cyc%0d got %b want %b", d, i, irq_w[d], m_irq[d]);
        end
        if ($urandom_range(0, 3) == 0) in_p[d] = in_p[d] ^ ($urandom & $urandom & $urandom);
      end
      address = 2'($urandom_range(0, 3));
      cs      = 3'($urandom);
      wr_n    = ($urandom_range(0, 3) != 0);
      wdata   = $urandom_range(0, 1) ? $urandom : ($urandom & $urandom);
      reset_n = ($urandom_range(0, 149) != 0);
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rise_irq();
    test_set_wins();
    test_level();
    test_width();
`ifdef MYSYSTEM_PIO_IN_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
